// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read-during-write result and an optional post-reset clear sequence.
module ram_sdp_be #(
    parameter int                    DEPTH         = 1024,
    parameter int                    WORD_WIDTH    = 32,
    parameter int                    BYTE_WIDTH    = 8,
    parameter int                    READ_LATENCY  = 1,
    parameter int                    RDW_MODE      = 0,
    parameter int                    INIT_ON_RESET = 1,
    parameter logic [WORD_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                                clk,
    input  logic                                rst_i,
    output logic                                init_done_o,
    input  logic                                wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]            wr_addr_i,
    input  logic [WORD_WIDTH/BYTE_WIDTH-1:0]    wr_be_i,
    input  logic [WORD_WIDTH-1:0]               wr_data_i,
    input  logic                                rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]            rd_addr_i,
    output logic [WORD_WIDTH-1:0]               rd_data_o,
    output logic                                rd_valid_o
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             NB         = WORD_WIDTH / BYTE_WIDTH;
    localparam logic [AW:0]    DEPTH_W    = DEPTH[AW:0];
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(DEPTH - 1);

    if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
        $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
    end
    if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ram_sdp_be: WORD_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            init_done_q;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic                  rd_in_range, wr_in_range;
    logic                  rd_accept, wr_accept, rdw_hit;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;
    logic [WORD_WIDTH-1:0] be_mask;

    logic                  valid1_q, oor_q, byp_q;
    logic [WORD_WIDTH-1:0] ram_q, byp_data_q, byp_mask_q, data1;

    assign rd_in_range = {1'b0, rd_addr_i} < DEPTH_W;
    assign wr_in_range = {1'b0, wr_addr_i} < DEPTH_W;
    assign rd_accept   = rd_en_i && (state_q == ST_READY) && !rst_i;
    assign wr_accept   = wr_en_i && (state_q == ST_READY) && !rst_i && wr_in_range && (|wr_be_i);
    assign rdw_hit     = (RDW_MODE == 1) && wr_accept && rd_accept && (rd_addr_i == wr_addr_i);
    assign init_done_o = init_done_q;

    // Clear sequencer: walks the array once, then parks in READY with the counter at the last word.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            cnt_q       <= '0;
            init_done_q <= (INIT_ON_RESET == 0);
        end else if (state_q == ST_INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr_i;
        mem_wdata = wr_data_i;
        mem_be    = wr_be_i;
        if (state_q == ST_INIT && !rst_i) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = INIT_VALUE;
            mem_be    = '1;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        be_mask = '0;
        for (int k = 0; k < NB; k++) begin
            be_mask[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be_i[k]}};
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; only the pipeline registers are reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_be[k]) begin
                    mem[mem_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // NOTE: non-blocking assignments make this read see the pre-write word on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ram_q <= '0;
        end else if (rd_accept && rd_in_range) begin
            ram_q <= mem[rd_addr_i];
        end
    end

    // Side-band for out-of-range reads and new-data bypass, captured alongside the array read.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid1_q   <= 1'b0;
            oor_q      <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else begin
            valid1_q <= rd_accept;
            if (rd_accept) begin
                oor_q      <= !rd_in_range;
                byp_q      <= rdw_hit;
                byp_data_q <= wr_data_i;
                byp_mask_q <= be_mask;
            end
        end
    end

    assign data1 = oor_q ? '0 :
                   byp_q ? ((ram_q & ~byp_mask_q) | (byp_data_q & byp_mask_q)) : ram_q;

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_data_o  = data1;
        assign rd_valid_o = valid1_q;
    end else begin : g_lat2
        logic                  valid2_q;
        logic [WORD_WIDTH-1:0] data2_q;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                valid2_q <= 1'b0;
                data2_q  <= '0;
            end else begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    data2_q <= data1;
                end
            end
        end

        assign rd_data_o  = data2_q;
        assign rd_valid_o = valid2_q;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: three instances cover clear sequence, byte lanes,
// 2-cycle pipelining, both read-during-write modes, reset behaviour and a non-power-of-two depth.
module tb_ram_sdp_be;

    logic        clk;
    logic        rst       [3];
    logic        init_done [3];
    logic        wr_en     [3];
    logic [3:0]  wr_addr   [3];
    logic [3:0]  wr_be     [3];
    logic [31:0] wr_data   [3];
    logic        rd_en     [3];
    logic [3:0]  rd_addr   [3];
    logic [31:0] rd_data   [3];
    logic        rd_valid  [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: depth 16, latency 1, old-data RDW, fill A5A5_A5A5.
    ram_sdp_be #(.DEPTH(16), .WORD_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(0),
                 .INIT_ON_RESET(1), .INIT_VALUE(32'hA5A5_A5A5)) u_a (
        .clk(clk), .rst_i(rst[0]), .init_done_o(init_done[0]),
        .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[0]), .wr_be_i(wr_be[0]), .wr_data_i(wr_data[0]),
        .rd_en_i(rd_en[0]), .rd_addr_i(rd_addr[0]), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]));

    // Instance 1: depth 16, latency 2, new-data RDW, fill 0.
    ram_sdp_be #(.DEPTH(16), .WORD_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(2), .RDW_MODE(1),
                 .INIT_ON_RESET(1), .INIT_VALUE(32'h0)) u_b (
        .clk(clk), .rst_i(rst[1]), .init_done_o(init_done[1]),
        .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr[1]), .wr_be_i(wr_be[1]), .wr_data_i(wr_data[1]),
        .rd_en_i(rd_en[1]), .rd_addr_i(rd_addr[1]), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]));

    // Instance 2: depth 12, latency 1, old-data RDW, fill 0.
    ram_sdp_be #(.DEPTH(12), .WORD_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(0),
                 .INIT_ON_RESET(1), .INIT_VALUE(32'h0)) u_c (
        .clk(clk), .rst_i(rst[2]), .init_done_o(init_done[2]),
        .wr_en_i(wr_en[2]), .wr_addr_i(wr_addr[2]), .wr_be_i(wr_be[2]), .wr_data_i(wr_data[2]),
        .rd_en_i(rd_en[2]), .rd_addr_i(rd_addr[2]), .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wr(input int i, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d; wr_be[i] = be;
        @(negedge clk);
        wr_en[i] = 1'b0;
    endtask

    task automatic rd(input int i, input logic [3:0] a, input logic [31:0] exp, input int lat,
                      input string tag);
        rd_en[i] = 1'b1; rd_addr[i] = a;
        @(negedge clk);
        rd_en[i] = 1'b0;
        repeat (lat - 1) @(negedge clk);
        check({tag, "_valid"}, {31'd0, rd_valid[i]}, 32'd1);
        check(tag, rd_data[i], exp);
    endtask

    task automatic rw(input int i, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be,
                      input logic [3:0] ra, input logic [31:0] exp, input int lat, input string tag);
        wr_en[i] = 1'b1; wr_addr[i] = wa; wr_data[i] = wd; wr_be[i] = be;
        rd_en[i] = 1'b1; rd_addr[i] = ra;
        @(negedge clk);
        wr_en[i] = 1'b0; rd_en[i] = 1'b0;
        repeat (lat - 1) @(negedge clk);
        check({tag, "_valid"}, {31'd0, rd_valid[i]}, 32'd1);
        check(tag, rd_data[i], exp);
    endtask

    task automatic wait_init(input int i, input int exp, input string tag);
        int n    = 0;
        bit seen = 1'b0;
        while (!init_done[i] && n < 200) begin
            @(negedge clk);
            n++;
            if (rd_valid[i]) seen = 1'b1;
        end
        check({tag, "_cycles"}, n, exp);
        check({tag, "_no_valid"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; wr_en[i] = 1'b0; wr_addr[i] = '0; wr_be[i] = '0; wr_data[i] = '0;
            rd_en[i] = 1'b0; rd_addr[i] = '0;
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_init_done%0d", i), {31'd0, init_done[i]}, 32'd0);
            check($sformatf("rst_valid%0d", i), {31'd0, rd_valid[i]}, 32'd0);
            check($sformatf("rst_data%0d", i), rd_data[i], 32'd0);
        end

        // Clear sequence with reads requested throughout INIT.
        rd_en[0] = 1'b1; rd_addr[0] = 4'd2;
        rst[0] = 1'b0;
        wait_init(0, 16, "init_a");
        rd_en[0] = 1'b0;
        rst[2] = 1'b0;
        wait_init(2, 12, "init_c");
        rst[1] = 1'b0;
        wait_init(1, 16, "init_b");

        for (int a = 0; a < 16; a++) rd(0, 4'(a), 32'hA5A5_A5A5, 1, $sformatf("fill_a%0d", a));

        // Byte lanes.
        wr(0, 4'd3, 32'h1122_3344, 4'hF);
        wr(0, 4'd3, 32'hDEAD_BEEF, 4'b0101);
        rd(0, 4'd3, 32'h11AD_33EF, 1, "be_merge");
        wr(0, 4'd3, 32'h0000_0000, 4'h0);
        rd(0, 4'd3, 32'h11AD_33EF, 1, "be_zero");

        // Read-during-write, old-data mode, and an independent different-address pair.
        wr(0, 4'd5, 32'h0, 4'hF);
        rw(0, 4'd5, 32'hFFFF_FFFF, 4'b0011, 4'd5, 32'h0000_0000, 1, "rdw_old");
        rd(0, 4'd5, 32'h0000_FFFF, 1, "rdw_old_after");
        rw(0, 4'd6, 32'h1234_5678, 4'hF, 4'd3, 32'h11AD_33EF, 1, "rw_indep");
        rd(0, 4'd6, 32'h1234_5678, 1, "rw_indep_wr");

        // Two-cycle latency, back-to-back reads.
        wr(1, 4'd0, 32'h0000_0100, 4'hF);
        wr(1, 4'd1, 32'h0000_0101, 4'hF);
        wr(1, 4'd2, 32'h0000_0102, 4'hF);
        check("lat_pre", {31'd0, rd_valid[1]}, 32'd0);
        rd_en[1] = 1'b1; rd_addr[1] = 4'd0;
        @(negedge clk); check("lat_n0_valid", {31'd0, rd_valid[1]}, 32'd0);
        rd_addr[1] = 4'd1;
        @(negedge clk); check("lat_n1_valid", {31'd0, rd_valid[1]}, 32'd1);
        check("lat_n1_data", rd_data[1], 32'h0000_0100);
        rd_addr[1] = 4'd2;
        @(negedge clk); check("lat_n2_valid", {31'd0, rd_valid[1]}, 32'd1);
        check("lat_n2_data", rd_data[1], 32'h0000_0101);
        rd_en[1] = 1'b0;
        @(negedge clk); check("lat_n3_valid", {31'd0, rd_valid[1]}, 32'd1);
        check("lat_n3_data", rd_data[1], 32'h0000_0102);
        @(negedge clk); check("lat_n4_valid", {31'd0, rd_valid[1]}, 32'd0);
        check("lat_n4_hold", rd_data[1], 32'h0000_0102);
        @(negedge clk); check("lat_n5_valid", {31'd0, rd_valid[1]}, 32'd0);
        check("lat_n5_hold", rd_data[1], 32'h0000_0102);

        // Read-during-write, new-data mode; a later write must not disturb an in-flight read.
        rw(1, 4'd5, 32'hFFFF_FFFF, 4'b0011, 4'd5, 32'h0000_FFFF, 2, "rdw_new");
        rd(1, 4'd5, 32'h0000_FFFF, 2, "rdw_new_after");
        rd_en[1] = 1'b1; rd_addr[1] = 4'd5;
        @(negedge clk);
        rd_en[1] = 1'b0;
        wr_en[1] = 1'b1; wr_addr[1] = 4'd5; wr_data[1] = 32'h1234_5678; wr_be[1] = 4'hF;
        @(negedge clk);
        wr_en[1] = 1'b0;
        check("late_wr_valid", {31'd0, rd_valid[1]}, 32'd1);
        check("late_wr_data", rd_data[1], 32'h0000_FFFF);
        rd(1, 4'd5, 32'h1234_5678, 2, "late_wr_after");

        // Reset with reads in flight.
        rd_en[1] = 1'b1; rd_addr[1] = 4'd0;
        @(negedge clk);
        rst[1] = 1'b1; rd_addr[1] = 4'd1;
        @(negedge clk);
        rd_en[1] = 1'b0;
        check("flush_valid0", {31'd0, rd_valid[1]}, 32'd0);
        check("flush_data0", rd_data[1], 32'd0);
        @(negedge clk);
        check("flush_valid1", {31'd0, rd_valid[1]}, 32'd0);
        check("flush_data1", rd_data[1], 32'd0);
        rst[1] = 1'b0;
        wait_init(1, 16, "reinit_b");
        rd(1, 4'd0, 32'h0, 2, "reinit_b_word0");

        // Reset mid-clear restarts from word 0.
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_init_busy", {31'd0, init_done[0]}, 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        wait_init(0, 16, "restart_a");
        rd(0, 4'd3, 32'hA5A5_A5A5, 1, "restart_a_word3");

        // Non-power-of-two depth and out-of-range addresses.
        wr(2, 4'd11, 32'hCAFE_F00D, 4'hF);
        wr(2, 4'd13, 32'hFFFF_FFFF, 4'hF);
        for (int a = 0; a < 12; a++)
            rd(2, 4'(a), (a == 11) ? 32'hCAFE_F00D : 32'h0, 1, $sformatf("d12_word%0d", a));
        rd(2, 4'd13, 32'h0, 1, "d12_oor_read");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
